poly_operand_sequencer: RTL and testbench



---
 rtl/poly_seq_pkg.sv | 17 +
 rtl/poly_seq_timer.sv | 22 ++
 rtl/poly_operand_sequencer.sv | 169 ++++++++++++++++
 tb/tb_poly_operand_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/poly_seq_pkg.sv
// poly_seq_pkg: shared state encoding, operand indices and result constants for the operand sequencer
package poly_seq_pkg;
    typedef enum logic [2:0] {
        IDLE,
        DRIVE_LOW,
        DRIVE_HIGH,
        WAIT_RES,
        HOLD_OUT
    } state_e;

    localparam logic [1:0] IDX_A = 2'd0;
    localparam logic [1:0] IDX_B = 2'd1;
    localparam logic [1:0] IDX_C = 2'd2;
    localparam logic [1:0] IDX_X = 2'd3;

    localparam logic [7:0] TIMEOUT_RES = 8'hFF;
endpackage

// File: rtl/poly_seq_timer.sv
// poly_seq_timer: loadable down-counter that stops at zero and flags it
module poly_seq_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    // load wins; otherwise count down and park at zero
    always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);

    // counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/poly_operand_sequencer.sv
// poly_operand_sequencer: replays {A,B,C,X} into the core's Go/DataIn protocol and returns its result
// Optional feature: define POLY_SEQ_TIMEOUT_EN to bound WAIT_RES and return 8'hFF with err set.
module poly_operand_sequencer
    import poly_seq_pkg::*;
#(
    parameter int GO_LOW_CYC  = 2,
    parameter int GO_HIGH_CYC = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic [7:0] in_c,
    input  logic [7:0] in_x,
    output logic       Go,
    output logic [7:0] DataIn,
    input  logic [7:0] DataResult,
    input  logic       ResultValid,
    output logic       res_valid,
    output logic [7:0] res_data,
    input  logic       res_ready,
    output logic       err
);
    localparam int MAXG = GO_LOW_CYC > GO_HIGH_CYC ? GO_LOW_CYC : GO_HIGH_CYC;
`ifdef POLY_SEQ_TIMEOUT_EN
    localparam int MAXC = MAXG > TIMEOUT_CYC ? MAXG : TIMEOUT_CYC;
`else
    localparam int MAXC = MAXG;
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif
    localparam int TW = $clog2(MAXC + 1);

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][7:0] op_q, op_d;
    logic [7:0]      din_q, din_d;
    logic            go_q, go_d;
    logic            in_ready_q, in_ready_d;
    logic            res_valid_q, res_valid_d;
    logic [7:0]      res_data_q, res_data_d;
    logic            tmr_load, tmr_zero;
    logic [TW-1:0]   tmr_val;
`ifdef POLY_SEQ_TIMEOUT_EN
    logic            err_q, err_d;
`endif

    poly_seq_timer #(.W(TW)) u_timer (
        .clk      (Clock),
        .rst_n    (Resetn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // next-state logic; Go and in_ready follow the state being entered so they line up with it
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op_d        = op_q;
        din_d       = din_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
`ifdef POLY_SEQ_TIMEOUT_EN
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
                op_d[IDX_A] = in_a;
                op_d[IDX_B] = in_b;
                op_d[IDX_C] = in_c;
                op_d[IDX_X] = in_x;
                idx_d       = IDX_A;
                din_d       = in_a;
                state_d     = DRIVE_LOW;
                tmr_load    = 1'b1;
                tmr_val     = TW'(GO_LOW_CYC - 1);
`ifdef POLY_SEQ_TIMEOUT_EN
                err_d       = 1'b0;
`endif
            end
            DRIVE_LOW: if (tmr_zero) begin
                state_d  = DRIVE_HIGH;
                tmr_load = 1'b1;
                tmr_val  = TW'(GO_HIGH_CYC - 1);
            end
            DRIVE_HIGH: if (tmr_zero) begin
                if (idx_q == IDX_X) begin
                    state_d  = WAIT_RES;
`ifdef POLY_SEQ_TIMEOUT_EN
                    tmr_load = 1'b1;
                    tmr_val  = TW'(TIMEOUT_CYC - 1);
`endif
                end else begin
                    idx_d    = idx_q + 2'd1;
                    din_d    = op_q[idx_d];
                    state_d  = DRIVE_LOW;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(GO_LOW_CYC - 1);
                end
            end
            WAIT_RES: begin
                if (ResultValid) begin
                    res_data_d  = DataResult;
                    res_valid_d = 1'b1;
                    state_d     = HOLD_OUT;
                end
`ifdef POLY_SEQ_TIMEOUT_EN
                else if (tmr_zero) begin
                    err_d       = 1'b1;
                    res_data_d  = TIMEOUT_RES;
                    res_valid_d = 1'b1;
                    state_d     = HOLD_OUT;
                end
`endif
            end
            HOLD_OUT: if (res_ready) begin
                res_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        go_d       = (state_d == DRIVE_HIGH);
        in_ready_d = (state_d == IDLE);
    end

    // state and registered outputs
    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) begin
            state_q     <= IDLE;
            idx_q       <= IDX_A;
            op_q        <= '0;
            din_q       <= '0;
            go_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            din_q       <= din_d;
            go_q        <= go_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end

`ifdef POLY_SEQ_TIMEOUT_EN
    // sticky timeout flag, cleared when the next set is accepted
    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) err_q <= 1'b0;
        else         err_q <= err_d;

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign Go        = go_q;
    assign DataIn    = din_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
endmodule

// File: tb/tb_poly_operand_sequencer.sv
// tb_poly_operand_sequencer: directed vectors against a behavioural polynomial core
module tb_poly_operand_sequencer;
    localparam int GO_LOW_CYC  = 2;
    localparam int GO_HIGH_CYC = 2;
    localparam int TIMEOUT_CYC = 64;
    localparam int LAT         = 6;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       in_valid = 1'b0;
    logic       res_ready = 1'b1;
    logic [7:0] in_a = '0, in_b = '0, in_c = '0, in_x = '0;
    logic       in_ready, Go, res_valid, err;
    logic [7:0] DataIn, res_data;
    logic       ResultValid;
    logic [7:0] DataResult;
    logic       mute = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clock = ~Clock;

    poly_operand_sequencer #(
        .GO_LOW_CYC  (GO_LOW_CYC),
        .GO_HIGH_CYC (GO_HIGH_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_c        (in_c),
        .in_x        (in_x),
        .Go          (Go),
        .DataIn      (DataIn),
        .DataResult  (DataResult),
        .ResultValid (ResultValid),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_ready   (res_ready),
        .err         (err)
    );

    // behavioural core: latches DataIn on each Go rise, result valid 5 cycles after the X-phase Go fall,
    // ResultValid stays high until the next Go rise
    logic       go_p;
    logic [2:0] ph, cnt;
    logic [7:0] ops [4];
    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            go_p <= 1'b0; ph <= '0; cnt <= '0; ResultValid <= 1'b0; DataResult <= '0;
        end else begin
            go_p <= Go;
            if (Go && !go_p) begin
                ResultValid <= 1'b0;
                ops[ph[1:0]] <= DataIn;
                ph <= ph + 3'd1;
            end
            if (!Go && go_p && ph == 3'd4) begin
                ph <= '0;
                cnt <= 3'd1;
            end else if (cnt == 3'd4) begin
                cnt <= '0;
                if (!mute) begin
                    ResultValid <= 1'b1;
                    DataResult <= (ops[0] * ops[3] + ops[1]) * ops[3] + ops[2];
                end
            end else if (cnt != 3'd0) cnt <= cnt + 3'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // offer one set, monitor the Go/DataIn replay, check the result and (if res_ready) the handshake
    task automatic run_set(input logic [7:0] a, b, c, x, e, input int exp_lat, input logic exp_err,
                           input string tag);
        logic [7:0] seen [4];
        logic [7:0] held = '0;
        logic       pg = 1'b0;
        int pulses = 0, hi = 0, lo = 0, hi_bad = 0, lo_bad = 0, din_bad = 0, fall = -1000, lat = -1;
        for (int i = 0; i < 4; i++) seen[i] = '0;
        @(negedge Clock);
        in_a = a; in_b = b; in_c = c; in_x = x; in_valid = 1'b1;
        check({tag, "_in_ready_idle"}, in_ready, 1);
        @(negedge Clock);
        in_valid = 1'b0;
        check({tag, "_in_ready_drop"}, in_ready, 0);
        for (int cyc = 0; cyc < 400 && lat < 0; cyc++) begin
            if (Go && !pg) begin
                if (pulses < 4) seen[pulses] = DataIn;
                held = DataIn;
                if (lo != GO_LOW_CYC) lo_bad++;
                hi = 1;
            end else if (Go) begin
                hi++;
                if (DataIn !== held) din_bad++;
            end else if (pg) begin
                if (hi != GO_HIGH_CYC) hi_bad++;
                pulses++;
                fall = cyc;
                lo = 1;
            end else lo++;
            if (res_valid) lat = cyc - fall;
            pg = Go;
            if (lat < 0) @(negedge Clock);
        end
        check({tag, "_go_pulses"}, pulses, 4);
        check({tag, "_go_high_len"}, hi_bad, 0);
        check({tag, "_go_low_len"}, lo_bad, 0);
        check({tag, "_datain_stable"}, din_bad, 0);
        check({tag, "_datain_seq"}, {seen[0], seen[1], seen[2], seen[3]}, {a, b, c, x});
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_res_data"}, res_data, e);
        check({tag, "_err"}, err, exp_err);
        if (res_ready) begin
            @(negedge Clock);
            check({tag, "_res_valid_clr"}, res_valid, 0);
            check({tag, "_in_ready_back"}, in_ready, 1);
        end
    endtask

    typedef struct {
        logic [7:0] a, b, c, x, e;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int rises;
        int bp_bad;
        logic pg;
        tbl[0] = '{8'd2,   8'd3,   8'd4,   8'd5,   8'd69};
        tbl[1] = '{8'd10,  8'd0,   8'd0,   8'd10,  8'd232};
        tbl[2] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        tbl[3] = '{8'd3,   8'd7,   8'd1,   8'd16,  8'd113};
        tbl[4] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0};

        Resetn = 1'b1;
        #1 Resetn = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_go", Go, 0);
        check("rst_datain", DataIn, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_err", err, 0);
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;

        for (int i = 0; i < 5; i++) run_set(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].x, tbl[i].e, LAT, 1'b0,
                                            $sformatf("vec%0d", i));

        run_set(8'd1, 8'd1, 8'd1, 8'd1, 8'd3, LAT, 1'b0, "b2b_1");
        run_set(8'd0, 8'd0, 8'd7, 8'd3, 8'd7, LAT, 1'b0, "b2b_2");

        res_ready = 1'b0;
        run_set(8'd7, 8'd1, 8'd2, 8'd3, 8'd68, LAT, 1'b0, "bp");
        bp_bad = 0;
        for (int i = 0; i < 20; i++) begin
            in_a = 8'd99; in_b = 8'd98; in_c = 8'd97; in_x = 8'd96; in_valid = 1'b1;
            @(negedge Clock);
            if (res_valid !== 1'b1 || res_data !== 8'd68 || in_ready !== 1'b0 || Go !== 1'b0) bp_bad++;
        end
        check("bp_hold", bp_bad, 0);
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge Clock);
        check("bp_release_valid", res_valid, 0);
        check("bp_release_ready", in_ready, 1);
        @(negedge Clock);
        check("bp_no_spurious_go", Go, 0);
        check("bp_still_idle", in_ready, 1);

        in_a = 8'd2; in_b = 8'd3; in_c = 8'd4; in_x = 8'd5; in_valid = 1'b1;
        @(negedge Clock);
        in_valid = 1'b0;
        rises = 0;
        pg = 1'b0;
        for (int cyc = 0; cyc < 100 && rises < 3; cyc++) begin
            if (Go && !pg) rises++;
            pg = Go;
            if (rises < 3) @(negedge Clock);
        end
        check("rst_mid_c_phase_reached", rises, 3);
        check("rst_mid_go_before", Go, 1);
        Resetn = 1'b0;
        #1;
        check("rst_mid_go", Go, 0);
        check("rst_mid_res_valid", res_valid, 0);
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_datain", DataIn, 0);
        @(negedge Clock);
        Resetn = 1'b1;
        run_set(8'd2, 8'd3, 8'd4, 8'd5, 8'd69, LAT, 1'b0, "after_rst");

`ifdef POLY_SEQ_TIMEOUT_EN
        mute = 1'b1;
        run_set(8'd1, 8'd2, 8'd3, 8'd4, 8'hFF, TIMEOUT_CYC, 1'b1, "timeout");
        mute = 1'b0;
        run_set(8'd1, 8'd2, 8'd3, 8'd4, 8'd27, LAT, 1'b0, "after_to");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
